muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: a is multiplicand/dividend/move source; b is multiplier/divisor.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels an operation in progress.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in CALC or FIN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port div_zero, output, 1 bit: set when a completed divide had b==0.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI/LO registers.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIN.
REQ-013 In IDLE with start=1 and abort=0, op MULTU/MULT/DIVU/DIV SHALL latch a, b and op and enter CALC with iteration counter = WIDTH.
REQ-014 In IDLE with start=1 and abort=0, op MTHI/MTLO SHALL write a to hi/lo at that edge, stay in IDLE, and assert neither busy nor done.
REQ-015 Reserved op codes with start=1 SHALL cause no state or register change.
REQ-016 Multiply SHALL be iterative shift-add, one multiplier bit per cycle, on operand magnitudes.
REQ-017 Signed multiply SHALL negate the 2*WIDTH product when a and b signs differ.
REQ-018 Divide SHALL be restoring, one quotient bit per cycle, on operand magnitudes.
REQ-019 Signed divide SHALL give the quotient sign a^b and the remainder the sign of a (truncating division).
REQ-020 The most-negative dividend divided by -1 SHALL give quotient = most-negative value and remainder = 0.
REQ-021 CALC SHALL decrement the counter each cycle and enter FIN when it reaches 0 (exactly WIDTH cycles in CALC).
REQ-022 In FIN, hi SHALL take the product upper half (multiply) or remainder (divide) and lo the product lower half or quotient; done=1 for that cycle only; next state IDLE.
REQ-023 Latency SHALL be: start sampled at edge t, done high in the cycle after edge t+WIDTH+1; busy high from edge t through edge t+WIDTH+1.
REQ-024 A divide with b==0 SHALL skip CALC and go directly to FIN, giving lo = all ones, hi = a, and div_zero=1.
REQ-025 div_zero SHALL be cleared at every other FIN and at every accepted MTHI/MTLO.
REQ-026 hi and lo SHALL stay stable from accept until FIN; they SHALL change only in FIN, on MTHI/MTLO, or at reset.
REQ-027 start while busy SHALL be ignored, with no queuing.
REQ-028 abort in CALC or FIN SHALL return to IDLE next edge with hi, lo and div_zero unchanged and done=0.
REQ-029 abort and start together in IDLE SHALL be treated as abort: nothing is accepted.
REQ-030 An operation SHALL read its latched a and b only; input changes after accept SHALL have no effect.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and the counter and operand registers SHALL be 0.
REQ-032 Reset assertion mid-operation SHALL take effect immediately, without waiting for clk, and the operation SHALL be lost.
REQ-033 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-034 MULT a=FFFFFFFD, b=00000005 -> done 34 cycles after accept edge; hi=FFFFFFFF, lo=FFFFFFF1.
REQ-035 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for 33 cycles.
REQ-036 DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-038 DIVU a=5, b=0 -> done two cycles after accept; div_zero=1, lo=FFFFFFFF, hi=00000005; then MTLO a=1234 -> lo=00001234, div_zero=0.
REQ-039 MULTU a=b=3 with abort pulsed at CALC cycle 10 -> busy drops, no done, hi/lo keep prior values; repeat with rst_n pulsed low mid-CALC -> hi=lo=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
//
// Multiplies use a shift-add datapath (one multiplier bit per cycle) and divides use
// a restoring datapath (one quotient bit per cycle). Both work on operand magnitudes,
// and the sign is fixed up at the end. Each arithmetic operation spends WIDTH cycles
// in CALC. A divide by zero skips CALC and goes straight to FIN. MTHI/MTLO write
// HI/LO directly from IDLE.
//
// Ports:
//   clk      - clock; all state updates on its rising edge
//   rst_n    - asynchronous active-low reset
//   start    - operation request, sampled only in IDLE
//   op       - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved
//   a, b     - a: multiplicand/dividend/move source, b: multiplier/divisor
//   abort    - cancels an operation in CALC or FIN; also blocks a start in IDLE
//   busy     - high while in CALC or FIN
//   done     - one-cycle completion pulse
//   div_zero - last completed divide had b == 0
//   hi, lo   - architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;        // only arithmetic ops are ever latched
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper, lower}: product, or {remainder, quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    // Operand magnitudes of the incoming request, used to seed the accumulator.
    logic [WIDTH-1:0] a_in_mag, b_in_mag;
    // Signs and magnitudes of the latched operands.
    logic             is_signed, is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    // Iteration datapath.
    logic [CW-1:0]      cnt_dec;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    // Sign-corrected results.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    always_comb begin
        a_in_mag = (op[0] && a[WIDTH-1]) ? -a : a;
        b_in_mag = (op[0] && b[WIDTH-1]) ? -b : b;

        is_signed = op_q[0];
        is_div    = op_q[1];
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_mag     = a_neg ? -a_q : a_q;
        b_mag     = b_neg ? -b_q : b_q;

        cnt_dec = cnt_q - CW'(1);

        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_mag : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the partial remainder,
        // then keep the subtraction only if it did not go negative.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag};
        if (div_trial[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        // The most-negative / -1 case needs no special handling: its quotient
        // magnitude 2^(WIDTH-1) is its own two's complement.
        prod_s = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quo_s  = (a_neg ^ b_neg) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s  = a_neg ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    case (op)
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            op_d  = op[1:0];
                            a_d   = a;
                            b_d   = b;
                            cnt_d = CW'(WIDTH);
                            if (op[1]) begin
                                acc_d = {{WIDTH{1'b0}}, a_in_mag};
                            end else begin
                                acc_d = {{WIDTH{1'b0}}, b_in_mag};
                            end
                            // A zero divisor has a fixed result, so the iterations are skipped.
                            state_d = (op[1] && (b == '0)) ? S_FIN : S_CALC;
                        end
                        OP_MTHI: begin
                            hi_d       = a;
                            div_zero_d = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d       = a;
                            div_zero_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            S_CALC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div ? div_next : mul_next;
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div) begin
                        if (b_q == '0) begin
                            lo_d       = '1;
                            hi_d       = a_q;
                            div_zero_d = 1'b1;
                        end else begin
                            lo_d       = quo_s;
                            hi_d       = rem_s;
                            div_zero_d = 1'b0;
                        end
                    end else begin
                        lo_d       = prod_s[WIDTH-1:0];
                        hi_d       = prod_s[2*WIDTH-1:WIDTH];
                        div_zero_d = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == S_CALC) || (state_q == S_FIN);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH = 32).
// The driver pushes expected results computed with plain 64-bit arithmetic. A
// monitor pops and compares them on every done pulse. It also checks latency and
// busy length, and that HI/LO/div_zero hold while the unit is busy.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Architectural HI/LO/div_zero as the model sees them.
    logic [W-1:0] arch_hi = '0;
    logic [W-1:0] arch_lo = '0;
    logic         arch_dz = 1'b0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Reference model: the arithmetic definition of each operation.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        logic [63:0] p;
        longint      sx, sy;
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        case (o)
            3'd0: begin
                p  = {32'd0, x} * {32'd0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            3'd1: begin
                p  = sx * sy;
                rh = p[63:32];
                rl = p[31:0];
            end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    rh  = x;
                    rl  = '1;
                    rdz = 1'b1;
                end else if (o == 3'd2) begin
                    rl = x / y;
                    rh = x % y;
                end else begin
                    // 64-bit signed division truncates toward zero; the low half
                    // also covers the most-negative / -1 case.
                    p  = sx / sy;
                    rl = p[31:0];
                    p  = sx % sy;
                    rh = p[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                chk("hold_hi", hi, arch_hi);
                chk("hold_lo", lo, arch_lo);
                chk("hold_dz", div_zero, arch_dz);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, want no pending completion (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("res_hi", hi, e.hi);
                    chk("res_lo", lo, e.lo);
                    chk("res_dz", div_zero, e.dz);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_len", busy_cnt, e.lat);
                    arch_hi = e.hi;
                    arch_lo = e.lo;
                    arch_dz = e.dz;
                end
                busy_cnt = 0;
            end else if (!busy) begin
                busy_cnt = 0;
            end
        end
    end

    // Issue one request at a negedge; returns shortly after a negedge with the unit idle.
    // abort_at / rst_at: index of the busy cycle at which to abort or reset (-1 = never).
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int abort_at, input int rst_at, input bit noise);
        exp_t         e;
        logic [W-1:0] h0, l0;
        logic         dz0;
        int           j;
        bit           was_reset;
        h0 = arch_hi;
        l0 = arch_lo;
        dz0 = arch_dz;
        was_reset = 1'b0;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        abort = 1'b0;
        if (o <= 3'd3) begin
            ref_op(o, x, y, e.hi, e.lo, e.dz);
            e.acc = cyc + 1;
            e.lat = (o[1] && (y == '0)) ? 1 : W + 1;
            if (abort_at < 0 && rst_at < 0) sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (o > 3'd3) begin
            chk("mv_busy", busy, 1'b0);
            chk("mv_done", done, 1'b0);
            case (o)
                3'd4: begin
                    chk("mthi_hi", hi, x);
                    chk("mthi_lo", lo, l0);
                    chk("mthi_dz", div_zero, 1'b0);
                    arch_hi = x;
                    arch_dz = 1'b0;
                end
                3'd5: begin
                    chk("mtlo_hi", hi, h0);
                    chk("mtlo_lo", lo, x);
                    chk("mtlo_dz", div_zero, 1'b0);
                    arch_lo = x;
                    arch_dz = 1'b0;
                end
                default: begin
                    chk("rsv_hi", hi, h0);
                    chk("rsv_lo", lo, l0);
                    chk("rsv_dz", div_zero, dz0);
                end
            endcase
            #1;
            return;
        end
        j = 0;
        while (busy && j < 4 * W) begin
            if (j == rst_at) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_hi", hi, '0);
                chk("rst_lo", lo, '0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_dz", div_zero, 1'b0);
                arch_hi = '0;
                arch_lo = '0;
                arch_dz = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                was_reset = 1'b1;
                break;
            end
            abort = (j == abort_at);
            if (noise) begin
                start = 1'($urandom);
                op = 3'($urandom);
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            j++;
        end
        abort = 1'b0;
        start = 1'b0;
        if (busy && !was_reset) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, want idle", j);
            finish_run();
        end
        if (abort_at >= 0 && !was_reset) begin
            chk("abort_cycle", j, abort_at + 1);
            chk("abort_hi", hi, h0);
            chk("abort_lo", lo, l0);
            chk("abort_dz", div_zero, dz0);
        end
        #1;
    endtask

    initial begin
        #1;
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_dz", div_zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd1, 32'hFFFFFFFD, 32'h00000005, -1, -1, 1'b1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 1'b0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        do_op(3'd3, 32'hFFFFFFF9, 32'h00000002, -1, -1, 1'b0);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);

        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, -1, -1, 1'b0);
        chk("divovf_hi", hi, 32'h00000000);
        chk("divovf_lo", lo, 32'h80000000);

        do_op(3'd2, 32'h00000005, 32'h00000000, -1, -1, 1'b0);
        chk("divz_hi", hi, 32'h00000005);
        chk("divz_lo", lo, 32'hFFFFFFFF);
        chk("divz_dz", div_zero, 1'b1);

        do_op(3'd5, 32'h00001234, 32'h0, -1, -1, 1'b0);
        chk("mtlo_after_lo", lo, 32'h00001234);
        chk("mtlo_after_dz", div_zero, 1'b0);

        do_op(3'd0, 32'd3, 32'd3, 10, -1, 1'b0);
        chk("abort10_hi", hi, 32'h00000005);
        chk("abort10_lo", lo, 32'h00001234);

        do_op(3'd0, 32'd3, 32'd3, -1, 12, 1'b0);
        // First request right after reset release must be accepted at the next edge.
        do_op(3'd0, 32'd7, 32'd6, -1, -1, 1'b0);
        chk("post_rst_lo", lo, 32'd42);

        for (int i = 0; i < 250; i++) begin
            logic [2:0]   o;
            logic [W-1:0] x, y;
            int           ab;
            o = 3'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = 32'hFFFFFFFF;
                2: x = 32'h80000000;
                3: y = 32'(x[3:0]);
                default: ;
            endcase
            ab = -1;
            if (o <= 3'd3 && $urandom_range(0, 15) == 0) begin
                ab = (o[1] && (y == '0)) ? 0 : $urandom_range(0, W);
            end
            do_op(o, x, y, ab, -1, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        finish_run();
    end

    initial begin
        #1000000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got run still active, want completion");
        finish_run();
    end

endmodule
